// File: rtl/fmap_stream_buffer_pkg.sv
// fmap_stream_buffer_pkg: shared types and sizing helpers for the feature-map stream buffer (package fmap_pkg).
// Contents: state_t (FILL/DRAIN), pe_count() lane count from kernels/cycles-per-pixel,
// clog2_min1() index width that never drops below one bit.
package fmap_pkg;
    typedef enum logic {FILL, DRAIN} state_t;

    function automatic int pe_count(input int nk, input int cpp);
        return (nk + cpp - 1) / cpp;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fmap_stream_buffer_if.sv
// fmap_stream_buffer_if: capture and stream handshake bundle of fmap_stream_buffer.
// in_valid[k]/in_data lanes/in_ready (capture side), out_valid/out_data/out_channel/out_last/out_ready
// (stream side), overflow (sticky drop flag). master = upstream/downstream environment, slave = buffer.
interface fmap_stream_buffer_if
    import fmap_pkg::*;
#(
    parameter int BitSize        = 4,
    parameter int NumberOfK      = 4,
    parameter int CyclesPerPixel = 2
);
    localparam int PE = pe_count(NumberOfK, CyclesPerPixel);
    localparam int CW = clog2_min1(NumberOfK);

    logic [NumberOfK-1:0]  in_valid;
    logic [PE*BitSize-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [BitSize-1:0]    out_data;
    logic [CW-1:0]         out_channel;
    logic                  out_last;
    logic                  out_ready;
    logic                  overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_channel, out_last, overflow
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_channel, out_last, overflow
    );
endinterface

// File: rtl/fmap_stream_buffer_channel_store.sv
// fmap_channel_store: one kernel's pooled map memory with its write counter and full flag.
// Ports: clk, res_n (async low), clr (restart the map), we (capture request), din (lane value),
// rd_idx/dout (drain read), full (map complete), full_next (complete after this edge).
// Macro FMAP_RELU_EN: negative (MSB set) captures are stored as zero.
module fmap_channel_store
    import fmap_pkg::*;
#(
    parameter int BitSize = 4,
    parameter int Depth   = 4
) (
    input  logic                         clk,
    input  logic                         res_n,
    input  logic                         clr,
    input  logic                         we,
    input  logic [BitSize-1:0]           din,
    input  logic [clog2_min1(Depth)-1:0] rd_idx,
    output logic [BitSize-1:0]           dout,
    output logic                         full,
    output logic                         full_next
);
    localparam int IW = clog2_min1(Depth);
    localparam int CW = $clog2(Depth + 1);

    logic [BitSize-1:0] mem [Depth];
    logic [CW-1:0]      cnt;
    logic [BitSize-1:0] wdata;
    logic               wr;

`ifdef FMAP_RELU_EN
    assign wdata = din[BitSize-1] ? '0 : din;
`else
    assign wdata = din;
`endif

    assign full      = cnt == CW'(Depth);
    assign wr        = we && !full;
    assign full_next = full || (wr && cnt == CW'(Depth - 1));
    assign dout      = mem[rd_idx];

    always_ff @(posedge clk or negedge res_n)
        if (!res_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (wr)
            cnt <= cnt + 1'b1;

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk)
        if (wr)
            mem[cnt[IW-1:0]] <= wdata;
endmodule

// File: rtl/fmap_stream_buffer.sv
// fmap_stream_buffer: buffers one full feature-map set from conv_pooling_layer and re-streams it channel-major.
// Ports: clk, res_n (async active-low), bus (fmap_stream_buffer_if.slave: capture lanes, stream
// handshake, sticky overflow). Macro FMAP_RELU_EN (in fmap_channel_store) clamps negative captures to zero.
module fmap_stream_buffer
    import fmap_pkg::*;
#(
    parameter int BitSize            = 4,
    parameter int NumberOfK          = 4,
    parameter int CyclesPerPixel     = 2,
    parameter int ProcessingElements = pe_count(NumberOfK, CyclesPerPixel),
    parameter int MapWidth           = 2
) (
    input logic                  clk,
    input logic                  res_n,
    fmap_stream_buffer_if.slave  bus
);
    localparam int Depth = MapWidth * MapWidth;
    localparam int IW    = clog2_min1(Depth);
    localparam int CW    = clog2_min1(NumberOfK);

    state_t             state, state_next;
    logic [CW-1:0]      ch;
    logic [IW-1:0]      idx;
    logic [NumberOfK-1:0] full, full_next;
    logic [BitSize-1:0] rd [NumberOfK];
    logic               fire, last, overflow;

    for (genvar k = 0; k < NumberOfK; k++) begin : g_store
        fmap_channel_store #(.BitSize(BitSize), .Depth(Depth)) u_store (
            .clk       (clk),
            .res_n     (res_n),
            .clr       (fire && last),
            .we        (bus.in_valid[k] && state == FILL),
            .din       (bus.in_data[(k % ProcessingElements)*BitSize +: BitSize]),
            .rd_idx    (idx),
            .dout      (rd[k]),
            .full      (full[k]),
            .full_next (full_next[k])
        );
    end

    assign last = ch == CW'(NumberOfK - 1) && idx == IW'(Depth - 1);
    assign fire = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge res_n)
        if (!res_n)
            state <= FILL;
        else
            state <= state_next;

    // Drain starts on the edge that completes the last map, so out_valid follows the final capture by one cycle.
    always_comb
        state_next = (state == FILL) ? (&full_next ? DRAIN : FILL) : ((fire && last) ? FILL : DRAIN);

    always_comb begin
        bus.in_ready    = state == FILL;
        bus.out_valid   = state == DRAIN;
        bus.out_data    = (state == DRAIN) ? rd[ch] : '0;
        bus.out_channel = ch;
        bus.out_last    = state == DRAIN && last;
        bus.overflow    = overflow;
    end

    // The final handshake wraps both counters to zero, leaving them ready for the next set.
    always_ff @(posedge clk or negedge res_n)
        if (!res_n) begin
            ch  <= '0;
            idx <= '0;
        end else if (fire) begin
            idx <= (idx == IW'(Depth - 1)) ? '0 : idx + 1'b1;
            ch  <= last ? '0 : ((idx == IW'(Depth - 1)) ? ch + 1'b1 : ch);
        end

    always_ff @(posedge clk or negedge res_n)
        if (!res_n)
            overflow <= 1'b0;
        else if ((state == FILL) ? |(bus.in_valid & full) : |bus.in_valid)
            overflow <= 1'b1;
endmodule
